layer_sequencer: RTL and testbench

//  Parametrised top-level sequencer for the layered network datapath. On start, steps

---
 rtl/net_pkg.sv | 17 +
 rtl/layer_seq_watchdog.sv | 32 +++
 rtl/layer_sequencer.sv | 136 +++++++++++++
 tb/tb_layer_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// Shared definitions for the layered network datapath: sequencer state encoding and
// default layer-count sizing, reused by the RAM controller and the layer-select muxes.
package net_pkg;

  localparam int NET_MAX_LAYERS = 4;
  localparam int NET_LAYER_W    = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_e;

endpackage

// File: rtl/layer_seq_watchdog.sv
// Wait-cycle watchdog for layer_sequencer: clears on i_clear, counts while i_enable,
// and flags the cycle in which the TIMEOUT_CYCLES-th enabled cycle is reached.
module layer_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The current enabled cycle is the last one allowed when the count already holds limit-1.
  assign o_expired = i_enable && (r_count == LIMIT_M1);

endmodule

// File: rtl/layer_sequencer.sv
// Top-level layer sequencer: launches each layer of a run, waits for its done, reports completion.
// Optional wait watchdog with sticky error state is enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer
  import net_pkg::*;
#(
  parameter int MAX_LAYERS     = NET_MAX_LAYERS,
  parameter int LAYER_W        = NET_LAYER_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W:0]   cfg_layers,
  input  logic               abort,
  input  logic               layer_done,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               last_layer,
  output logic               busy,
  output logic               net_done,
  output logic               error,
  output logic [2:0]         dbg_state
);

  // Handshake: layer_start is a one-cycle launch strobe with no ready; the controller answers
  // with layer_done, which is only looked at in WAIT, so a level left over from the previous
  // layer (or present during LAUNCH) is never taken as completion of the new one.

  localparam logic [LAYER_W:0] MAX_L = (LAYER_W + 1)'(MAX_LAYERS);

  state_e             r_state;
  logic [LAYER_W-1:0] r_idx;
  logic [LAYER_W:0]   r_run_layers;

  state_e             w_next_state;
  logic [LAYER_W-1:0] w_next_idx;
  logic [LAYER_W:0]   w_next_run;
  logic [LAYER_W:0]   w_cfg_clamped;
  logic               w_is_last;
  logic               w_wd_expired;

  if (MAX_LAYERS < 1 || (2 ** LAYER_W) < MAX_LAYERS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    // Out-of-range parameters show up as this named block in the elaborated hierarchy.
  end

  assign w_cfg_clamped = (cfg_layers > MAX_L) ? MAX_L : cfg_layers;
  assign w_is_last     = ({1'b0, r_idx} == (r_run_layers - 1'b1));

`ifdef LAYER_SEQ_TIMEOUT_EN
  layer_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state == S_LAUNCH),
    .i_enable  (r_state == S_WAIT),
    .o_expired (w_wd_expired)
  );
`else
  assign w_wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_run_layers <= '0;
    end else begin
      r_state      <= w_next_state;
      r_idx        <= w_next_idx;
      r_run_layers <= w_next_run;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_run   = r_run_layers;
    // ERR is sticky: only a new start or reset leaves it, so abort does not apply there.
    if (abort && (r_state != S_IDLE) && (r_state != S_ERR)) begin
      w_next_state = S_IDLE;
      w_next_idx   = '0;
    end else begin
      case (r_state)
`ifdef LAYER_SEQ_TIMEOUT_EN
        S_IDLE, S_ERR: begin
`else
        S_IDLE: begin
`endif
          if (start) begin
            w_next_run   = w_cfg_clamped;
            w_next_idx   = '0;
            w_next_state = (w_cfg_clamped == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: w_next_state = S_WAIT;
        S_WAIT: begin
          if (layer_done) begin
            w_next_state = S_ADVANCE;
          end else if (w_wd_expired) begin
            w_next_state = S_ERR;
          end
        end
        S_ADVANCE: begin
          if (w_is_last) begin
            w_next_state = S_DONE;
          end else begin
            w_next_idx   = r_idx + 1'b1;
            w_next_state = S_LAUNCH;
          end
        end
        S_DONE: begin
          w_next_idx   = '0;
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_idx   = '0;
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  assign layer_start = (r_state == S_LAUNCH);
  assign layer_idx   = r_idx;
  assign busy        = (r_state != S_IDLE) && (r_state != S_ERR);
  assign last_layer  = busy && w_is_last;
  assign net_done    = (r_state == S_DONE);
  assign dbg_state   = r_state;
`ifdef LAYER_SEQ_TIMEOUT_EN
  assign error       = (r_state == S_ERR);
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (MAX_LAYERS=4, LAYER_W=2, TIMEOUT_CYCLES=16).
// The watchdog scenario is built only when LAYER_SEQ_TIMEOUT_EN is defined.
module tb_layer_sequencer;
  import net_pkg::*;

  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          layer_done = 1'b0;
  logic [LW:0]   cfg_layers = '0;
  logic          layer_start, last_layer, busy, net_done, error;
  logic [LW-1:0] layer_idx;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_done = 0;
  // Expected {last_layer, layer_idx} at each launch pulse, in order.
  logic [LW:0] exp_q[$];

  layer_sequencer #(
    .MAX_LAYERS     (4),
    .LAYER_W        (LW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_layers  (cfg_layers),
    .abort       (abort),
    .layer_done  (layer_done),
    .layer_start (layer_start),
    .layer_idx   (layer_idx),
    .last_layer  (last_layer),
    .busy        (busy),
    .net_done    (net_done),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (layer_start) begin
        n_start++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL launch_unexpected observed idx=%0d expected no launch", layer_idx);
        end else begin
          chk("launch_last_idx", {last_layer, layer_idx}, exp_q.pop_front());
        end
      end
      if (net_done) n_done++;
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int cfg);
    cfg_layers = (LW + 1)'(cfg);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in LAUNCH; returns in the cycle after ADVANCE (next LAUNCH or DONE).
  task automatic serve_layer(input int gap, input string tag);
    tick();
    chk({tag, "_wait"}, dbg_state, S_WAIT);
    chk({tag, "_wait_nostart"}, layer_start, 1'b0);
    repeat (gap) tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    chk({tag, "_adv"}, dbg_state, S_ADVANCE);
    tick();
  endtask

  task automatic run_seq(input int cfg, input int n, input string tag);
    int s0;
    int d0;
    logic lst;
    s0 = n_start;
    d0 = n_done;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1);
      exp_q.push_back({lst, LW'(i)});
    end
    launch(cfg);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_launch_state"}, dbg_state, S_LAUNCH);
      chk({tag, "_launch_idx"}, layer_idx, i);
      serve_layer(4, tag);
    end
    chk({tag, "_net_done"}, net_done, 1'b1);
    chk({tag, "_done_busy"}, busy, 1'b1);
    tick();
    chk({tag, "_idle"}, dbg_state, S_IDLE);
    chk({tag, "_idle_idx"}, layer_idx, 0);
    chk({tag, "_idle_net_done"}, net_done, 1'b0);
    chk({tag, "_n_start"}, n_start - s0, n);
    chk({tag, "_n_done"}, n_done - d0, 1);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int s0;
    // reset state
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_idx", layer_idx, 0);
    chk("rst_start", layer_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_net_done", net_done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_last", last_layer, 1'b0);
    tick();

    // three layers, then single-layer and clamped runs
    run_seq(3, 3, "t1");
    run_seq(1, 1, "t1b");

    // zero layers: straight to DONE, one busy cycle, no launch
    s0 = n_start;
    launch(0);
    chk("t2_state", dbg_state, S_DONE);
    chk("t2_net_done", net_done, 1'b1);
    chk("t2_busy", busy, 1'b1);
    chk("t2_last", last_layer, 1'b0);
    tick();
    chk("t2_idle_busy", busy, 1'b0);
    chk("t2_idle_net_done", net_done, 1'b0);
    chk("t2_no_launch", n_start - s0, 0);

    run_seq(7, 4, "t3");
    run_seq(4, 4, "t3b");

    // abort in WAIT at layer 1
    d0 = n_done;
    exp_q.push_back({1'b0, 2'd0});
    exp_q.push_back({1'b0, 2'd1});
    launch(3);
    tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick();
    chk("t4_idx1", layer_idx, 1);
    tick();
    chk("t4_wait", dbg_state, S_WAIT);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_state", dbg_state, S_IDLE);
    chk("t4_abort_idx", layer_idx, 0);
    chk("t4_abort_busy", busy, 1'b0);
    chk("t4_abort_start", layer_start, 1'b0);
    tick();
    chk("t4_no_net_done", n_done - d0, 0);
    // abort in IDLE is a no-op; start with abort in IDLE starts a run from layer 0
    abort = 1'b1;
    tick();
    chk("t4_idle_abort", dbg_state, S_IDLE);
    exp_q.push_back({1'b0, 2'd0});
    exp_q.push_back({1'b1, 2'd1});
    cfg_layers = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t4_restart_state", dbg_state, S_LAUNCH);
    chk("t4_restart_idx", layer_idx, 0);
    serve_layer(2, "t4a");
    serve_layer(2, "t4b");
    chk("t4_net_done", net_done, 1'b1);
    tick();

    // layer_done held through LAUNCH; start while busy ignored
    exp_q.push_back({1'b0, 2'd0});
    exp_q.push_back({1'b1, 2'd1});
    cfg_layers = 3'd2;
    start = 1'b1;
    layer_done = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_launch", dbg_state, S_LAUNCH);
    tick();
    chk("t5_done_ignored", dbg_state, S_WAIT);
    tick();
    layer_done = 1'b0;
    chk("t5_done_taken", dbg_state, S_ADVANCE);
    tick();
    chk("t5_idx1", layer_idx, 1);
    cfg_layers = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy_start_state", dbg_state, S_WAIT);
    chk("t5_busy_start_idx", layer_idx, 1);
    chk("t5_busy_start_last", last_layer, 1'b1);
    repeat (2) tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick();
    chk("t5_net_done", net_done, 1'b1);
    tick();
    chk("t5_idle", dbg_state, S_IDLE);

    // reset mid-run
    exp_q.push_back({1'b0, 2'd0});
    launch(3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_state", dbg_state, S_IDLE);
    chk("t7_idx", layer_idx, 0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_last", last_layer, 1'b0);
    chk("t7_start", layer_start, 1'b0);
    chk("t7_net_done", net_done, 1'b0);
    tick();
    run_seq(2, 2, "t7r");

`ifdef LAYER_SEQ_TIMEOUT_EN
    // watchdog: 16 WAIT cycles without layer_done -> ERR
    exp_q.push_back({1'b0, 2'd0});
    launch(2);
    tick();
    repeat (15) tick();
    chk("t6_wait16", dbg_state, S_WAIT);
    chk("t6_wait16_err", error, 1'b0);
    tick();
    chk("t6_err_state", dbg_state, S_ERR);
    chk("t6_error", error, 1'b1);
    chk("t6_busy", busy, 1'b0);
    tick();
    chk("t6_sticky", error, 1'b1);
    exp_q.push_back({1'b1, 2'd0});
    launch(1);
    chk("t6_cleared", error, 1'b0);
    chk("t6_relaunch", layer_start, 1'b1);
    serve_layer(2, "t6");
    chk("t6_net_done", net_done, 1'b1);
    tick();
`endif

    chk("final_q_empty", exp_q.size(), 0);
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
